// File: rtl/instr_mem_responder_pkg.sv
// Shared types and constants for the instruction memory responder.
package instr_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic int word_idx_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/imem_prefetch_buf.sv
// One-entry next-word buffer with address compare; a write to the buffered
// word (or to the word being filled on the same edge) leaves it invalid.
module imem_prefetch_buf #(
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fill_en,
  input  logic [31:0]   fill_addr,
  input  logic [31:0]   fill_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [31:0]   lookup_addr,
  output logic          hit,
  output logic [31:0]   data
);

  logic        vld;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic        wr_kills_buf;
  logic        wr_kills_fill;

  assign wr_kills_buf  = wr_en && vld && (buf_addr[IW+1:2] == wr_idx);
  assign wr_kills_fill = wr_en && (fill_addr[IW+1:2] == wr_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (fill_en) begin
      // fill_data is the pre-write word, so a colliding write must not validate it
      vld      <= !wr_kills_fill;
      buf_addr <= fill_addr;
      buf_data <= fill_data;
    end else if (wr_kills_buf) begin
      vld <= 1'b0;
    end
  end

  assign hit  = vld && (lookup_addr == buf_addr);
  assign data = buf_data;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: preloadable word memory, WAIT_CYCLES wait states,
// valid/ready on both sides. Optional next-word buffer under IMEM_PREFETCH_EN.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        rsp_ready,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int IW = word_idx_width(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  function automatic logic in_range(input logic [31:0] a);
    return (a >> (IW + 2)) == 32'd0;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q;
  logic        accept, enter_resp;
  logic [31:0] fetch_addr, fetch_data;
  logic        fetch_err;
  logic        pf_hit;
  logic [31:0] pf_data;
  logic        load_ok;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign load_ok   = load_en && in_range(load_addr);

  // A fetch entering RESP straight from IDLE has not been captured in addr_q yet
  assign fetch_addr = (state == IDLE) ? req_addr : addr_q;
  assign fetch_err  = (fetch_addr[1:0] != 2'b00) || !in_range(fetch_addr);

  always_comb begin
    fetch_data = NOP_INSTR;
    if (!fetch_err) begin
      if (state == IDLE && pf_hit) fetch_data = pf_data;
      else                         fetch_data = mem[fetch_addr[IW+1:2]];
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0 || pf_hit) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) addr_q <= req_addr;
      if (enter_resp) begin
        rsp_instr <= fetch_data;
        rsp_err   <= fetch_err;
      end
    end
  end

  // Program storage is deliberately left out of reset
  always_ff @(posedge CLK) begin
    if (load_ok) mem[load_addr[IW+1:2]] <= load_data;
  end

`ifdef IMEM_PREFETCH_EN
  logic [31:0] next_addr;
  logic [31:0] next_data;
  logic        fill_en;

  assign next_addr = addr_q + 32'd4;
  assign next_data = mem[next_addr[IW+1:2]];
  assign fill_en   = rsp_valid && rsp_ready && !rsp_err && in_range(next_addr);

  imem_prefetch_buf #(.IW(IW)) u_prefetch_buf (
    .clk         (CLK),
    .rst_n       (Reset),
    .fill_en     (fill_en),
    .fill_addr   (next_addr),
    .fill_data   (next_data),
    .wr_en       (load_ok),
    .wr_idx      (load_addr[IW+1:2]),
    .lookup_addr (req_addr),
    .hit         (pf_hit),
    .data        (pf_data)
  );
`else
  assign pf_hit  = 1'b0;
  assign pf_data = NOP_INSTR;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder (DEPTH_WORDS=256, WAIT_CYCLES=1).
module tb_instr_mem_responder;

  logic        CLK, Reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_err, rsp_ready;
  logic [31:0] rsp_instr;
  logic        load_en;
  logic [31:0] load_addr, load_data;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h00000013;
  logic [31:0] w [8];
  localparam logic [31:0] W255 = 32'hDEADC0DE;
  localparam logic [31:0] NEW2 = 32'h11223344;
  localparam logic [31:0] NEW5 = 32'h55667788;

  instr_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // lat counts edges from the accept edge (inclusive) to the one raising rsp_valid
  task automatic fetch(input logic [31:0] a, output logic [31:0] instr,
                       output logic err, output int lat);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0; req_addr = 32'hDEADBEEF;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    instr = rsp_instr;
    err   = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [31:0] gi;
    logic        ge;
    int          gl;
    int          n;

    w[0] = 32'h00500093; w[1] = 32'h00100113; w[2] = 32'h002081B3; w[3] = 32'h40310233;
    w[4] = 32'h00A00293; w[5] = 32'h00128293; w[6] = 32'hFE029EE3; w[7] = 32'h0000006F;

    vt[0] = '{32'h00000000, w[0], 1'b0, 2};
    vt[1] = '{32'h000003FC, W255, 1'b0, 2};
    vt[2] = '{32'h00000006, NOP,  1'b1, 2};
    vt[3] = '{32'h00000400, NOP,  1'b1, 2};
    vt[4] = '{32'h00000008, w[2], 1'b0, 2};
    vt[5] = '{32'h00000001, NOP,  1'b1, 2};
    vt[6] = '{32'hFFFFFFFC, NOP,  1'b1, 2};
    vt[7] = '{32'h0000001C, w[7], 1'b0, 2};

    Reset = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_instr", rsp_instr, 32'd0);
    chk("reset_rsp_err",   32'(rsp_err), 32'd0);
    Reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) load(32'(i * 4), w[i]);
    load(32'h000003FC, W255);
    load(32'h00000400, 32'hBAD0BAD0);  // out of range, must not alias onto word 0

    for (int i = 0; i < 8; i++) begin
      fetch(vt[i].addr, gi, ge, gl);
      chk($sformatf("vec%0d_instr", i), gi, vt[i].instr);
      chk($sformatf("vec%0d_err", i), 32'(ge), 32'(vt[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(gl), 32'(vt[i].lat));
    end

    // Consumer stall: response held stable, then handshake with a request pending
    req_valid = 1'b1; req_addr = 32'h0000000C;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d_instr", c), rsp_instr, w[3]);
      chk($sformatf("stall%0d_req_ready", c), 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h00000004;
    tick();
    rsp_ready = 1'b0;
    chk("handshake_idle_req_ready", 32'(req_ready), 32'd1);
    chk("handshake_no_accept", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    tick();
    tick();
    chk("handshake_still_idle", 32'(req_ready), 32'd1);

    // Write to the word being captured on the same edge: old data returned
    req_valid = 1'b1; req_addr = 32'h00000008;
    tick();
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 32'h00000008; load_data = NEW2;
    tick();
    load_en = 1'b0;
    chk("prewrite_valid", 32'(rsp_valid), 32'd1);
    chk("prewrite_instr", rsp_instr, w[2]);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    fetch(32'h00000008, gi, ge, gl);
    chk("postwrite_instr", gi, NEW2);

    // Reset while waiting drops the fetch at once
    req_valid = 1'b1; req_addr = 32'h00000010;
    tick();
    req_valid = 1'b0;
    chk("wait_state_req_ready", 32'(req_ready), 32'd0);
    Reset = 1'b0;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    #2;
    Reset = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rsp_valid) n++;
    end
    chk("no_rsp_after_reset", 32'(n), 32'd0);
    fetch(32'h00000000, gi, ge, gl);
    chk("mem_survives_reset", gi, w[0]);

`ifdef IMEM_PREFETCH_EN
    fetch(32'h00000010, gi, ge, gl);
    chk("pf_first_lat", 32'(gl), 32'd2);
    fetch(32'h00000014, gi, ge, gl);
    chk("pf_hit_lat", 32'(gl), 32'd1);
    chk("pf_hit_instr", gi, w[5]);
    fetch(32'h00000010, gi, ge, gl);
    chk("pf_refetch_lat", 32'(gl), 32'd2);
    load(32'h00000014, NEW5);
    fetch(32'h00000014, gi, ge, gl);
    chk("pf_inval_lat", 32'(gl), 32'd2);
    chk("pf_inval_instr", gi, NEW5);
`else
    fetch(32'h00000010, gi, ge, gl);
    chk("seq_first_lat", 32'(gl), 32'd2);
    fetch(32'h00000014, gi, ge, gl);
    chk("seq_next_lat", 32'(gl), 32'd2);
    chk("seq_next_instr", gi, w[5]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: instruction words stored; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra wait states per fetch; range 0..15.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: a fetch request is present.
REQ-006 SHALL have port req_addr, input, 32 bits: byte address of the fetch, driven by the PC.
REQ-007 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port rsp_valid, output, 1 bit: the response is present.
REQ-009 SHALL have port rsp_instr, output, 32 bits: the fetched instruction word.
REQ-010 SHALL have port rsp_err, output, 1 bit: the fetch was misaligned or out of range.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-012 SHALL have ports load_en (1 bit), load_addr (32 bits) and load_data (32 bits), all inputs: the program preload write port.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge with req_valid&&req_ready.
- On accept, if WAIT_CYCLES=0 the FSM SHALL go to RESP.
- Otherwise it SHALL go to WAIT with a counter loaded with WAIT_CYCLES-1.
REQ-015 In WAIT, the FSM SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
- Result: rsp_valid rises exactly WAIT_CYCLES+1 edges after the accept edge.
REQ-016 SHALL capture req_addr at accept; later changes to req_addr SHALL have no effect on the in-flight fetch.
REQ-017 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-018 SHALL set rsp_err=1 and rsp_instr=32'h00000013 (NOP) when addr[1:0]!=0 or addr>=DEPTH_WORDS*4.
REQ-019 On the edge entering RESP, SHALL register rsp_instr/rsp_err and hold them stable while rsp_valid=1.
REQ-020 SHALL leave RESP for IDLE on the edge with rsp_valid&&rsp_ready; no new request is accepted in that same cycle.
REQ-021 SHALL write load_data to word load_addr[log2(DEPTH_WORDS)+1:2] on any edge with load_en=1, in any state.
- Writes with out-of-range load_addr SHALL be ignored.
REQ-022 When a write and the RESP-entry capture hit the same word on the same edge, the response SHALL carry the pre-write data.

Reset
REQ-023 Reset=0 SHALL force, immediately and asynchronously: state IDLE, req_ready=1, rsp_valid=0, rsp_instr=0, rsp_err=0, wait counter 0, prefetch buffer invalid.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 Reset asserted mid-fetch SHALL drop the in-flight fetch with no response issued.

Configuration
REQ-026 Macro IMEM_PREFETCH_EN defined: after each response handshake for a non-error address A, SHALL load a one-entry buffer with word A+4 and its address, if A+4 is in range.
- A subsequent request to exactly A+4 while the buffer is valid SHALL skip WAIT: rsp_valid rises 1 edge after accept.
- A load_en write to the buffered word SHALL invalidate the buffer.
REQ-027 Macro IMEM_PREFETCH_EN undefined: no buffer SHALL exist and every fetch SHALL take WAIT_CYCLES+1 edges.

Structure
REQ-028 A shared package SHALL hold: the FSM state enum, the NOP constant 32'h00000013, and the word-index width function.
REQ-029 SHALL contain one sub-module, imem_prefetch_buf (the buffer plus its hit compare), instantiated only under IMEM_PREFETCH_EN.

Verification
REQ-030 Reset, preload word0=0x00500093, WAIT_CYCLES=1, request addr 0x0 -> rsp_valid high 2 edges after accept, rsp_instr=0x00500093, rsp_err=0.
REQ-031 Request addr 0x6 -> rsp_err=1, rsp_instr=0x00000013.
REQ-032 Request addr 0x400 with DEPTH_WORDS=256 -> rsp_err=1, rsp_instr=0x00000013.
REQ-033 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_instr stable, req_ready=0; raise rsp_ready -> IDLE next edge.
REQ-034 Drive Reset low while in WAIT -> rsp_valid=0 and req_ready=1 immediately; no response follows.
REQ-035 With IMEM_PREFETCH_EN: fetch 0x10, then 0x14 -> second response 1 edge after accept.
- Repeat with a load_en write to 0x14 in between -> full latency, and the new data is returned.
